// File: rtl/ikbd_keyscan_tx.sv
// ikbd_keyscan_tx
// Walks the 15x8 Atari key matrix one column per scan slot, compares each
// column against a stored snapshot, queues a make/break byte for every
// changed key and ships the queued bytes out as 8N1 serial frames.
//
// Ports
//   clk       system clock (2 MHz nominal)
//   reset     asynchronous reset, active low (0 = reset)
//   matrix    key matrix, 15 columns of 8 bits; 0 = pressed, 1 = released
//   enable    1 = scanning advances; 0 = scan timer holds (TX still drains)
//   tx        serial data out, idle high
//   tx_busy   high while a frame is on the line
//   fifo_cnt  current event FIFO occupancy
module ikbd_keyscan_tx #(
    parameter int SCAN_DIV   = 2000,
    parameter int BAUD_DIV   = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] matrix [14:0],
    input  logic       enable,
    output logic       tx,
    output logic       tx_busy,
    output logic [4:0] fifo_cnt
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_MAX = TW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(BAUD_DIV - 1);
    localparam logic [4:0]    CNT_FULL  = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_WAIT, S_LATCH, S_WALK} scan_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    scan_state_t     scan_state_q, scan_state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      col_q, col_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      cur_q, cur_d;
    logic [119:0]    snap_q, snap_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      cnt_q, cnt_d;

    tx_state_t       tx_state_q, tx_state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      txbit_q, txbit_d;
    logic [7:0]      shift_q, shift_d;

    logic            push;
    logic            pop;
    logic [6:0]      key_idx;
    logic [7:0]      push_byte;
    logic            fifo_full;
    logic            fifo_empty;

    // {col,bit} is col*8+bit, which doubles as the snapshot bit index;
    // the key code is that plus one, and bit 7 of the byte marks a break.
    assign key_idx    = {col_q, bit_q};
    assign push_byte  = {cur_q[bit_q], key_idx + 7'd1};
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign fifo_empty = (cnt_q == 5'd0);

    // Scanner: wait out the slot, latch one column, then walk its 8 bits.
    // A change found while the FIFO is full leaves the snapshot untouched
    // so the same key is seen again on the next visit to this column.
    always_comb begin
        scan_state_d = scan_state_q;
        timer_d      = timer_q;
        col_d        = col_q;
        bit_d        = bit_q;
        cur_d        = cur_q;
        snap_d       = snap_q;
        push         = 1'b0;
        case (scan_state_q)
            S_WAIT: begin
                if (enable) begin
                    if (timer_q == TIMER_MAX) begin
                        scan_state_d = S_LATCH;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_LATCH: begin
                cur_d        = matrix[col_q];
                bit_d        = 3'd0;
                scan_state_d = S_WALK;
            end
            S_WALK: begin
                if ((cur_q[bit_q] != snap_q[key_idx]) && !fifo_full) begin
                    push            = 1'b1;
                    snap_d[key_idx] = cur_q[bit_q];
                end
                if (bit_q == 3'd7) begin
                    col_d        = (col_q == 4'd14) ? 4'd0 : col_q + 4'd1;
                    timer_d      = '0;
                    scan_state_d = S_WAIT;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            default: scan_state_d = S_WAIT;
        endcase
    end

    // Event FIFO: pointers wrap naturally because the depth is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_byte;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 5'd1;
            2'b01:   cnt_d = cnt_q - 5'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Serial transmitter: the head byte is popped the cycle the frame is
    // committed, and at the end of STOP a waiting byte starts the next frame
    // straight away so back-to-back frames have no idle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        baud_d     = baud_q;
        txbit_d    = txbit_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    baud_d     = '0;
                    tx_state_d = T_START;
                end
            end
            T_START: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d     = '0;
                    txbit_d    = 3'd0;
                    tx_state_d = T_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            T_DATA: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (txbit_q == 3'd7) begin
                        tx_state_d = T_STOP;
                    end else begin
                        txbit_d = txbit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            T_STOP: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_d    = mem_q[rd_ptr_q];
                        tx_state_d = T_START;
                    end else begin
                        tx_state_d = T_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Line level comes straight from the TX state, so an asserted reset
    // forces the line back high in the same cycle.
    always_comb begin
        tx = 1'b1;
        case (tx_state_q)
            T_START: tx = 1'b0;
            T_DATA:  tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign tx_busy  = (tx_state_q != T_IDLE);
    assign fifo_cnt = cnt_q;

    // All state registers; the snapshot resets to "all released".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_state_q <= S_WAIT;
            timer_q      <= '0;
            col_q        <= 4'd0;
            bit_q        <= 3'd0;
            cur_q        <= 8'hFF;
            snap_q       <= '1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= 5'd0;
            tx_state_q   <= T_IDLE;
            baud_q       <= '0;
            txbit_q      <= 3'd0;
            shift_q      <= 8'hFF;
        end else begin
            scan_state_q <= scan_state_d;
            timer_q      <= timer_d;
            col_q        <= col_d;
            bit_q        <= bit_d;
            cur_q        <= cur_d;
            snap_q       <= snap_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            tx_state_q   <= tx_state_d;
            baud_q       <= baud_d;
            txbit_q      <= txbit_d;
            shift_q      <= shift_d;
        end
    end

endmodule

// File: tb/tb_ikbd_keyscan_tx.sv
// tb_ikbd_keyscan_tx
// Bench for ikbd_keyscan_tx. Instance A (SCAN_DIV=16, BAUD_DIV=4,
// FIFO_DEPTH=4) takes the single-key vector table and the multi-cycle
// sequences; instance B (BAUD_DIV=1000) holds the line busy so the FIFO
// fills up. Frames are decoded from the tx pin and compared with
// hand-computed key bytes.
module tb_ikbd_keyscan_tx;

    logic       clk;
    logic       resetA, resetB;
    logic       enableA, enableB;
    logic [7:0] matrixA [14:0];
    logic [7:0] matrixB [14:0];
    logic       txA, txB;
    logic       busyA, busyB;
    logic [4:0] cntA, cntB;

    int testsRun;
    int failCount;
    int maxCntB;

    typedef struct {
        string      name;
        int         col;
        int         bitn;
        logic       level;
        logic [7:0] expByte;
    } vec_t;

    vec_t vecs [8];

    ikbd_keyscan_tx #(.SCAN_DIV(16), .BAUD_DIV(4), .FIFO_DEPTH(4)) dutA (
        .clk(clk), .reset(resetA), .matrix(matrixA), .enable(enableA),
        .tx(txA), .tx_busy(busyA), .fifo_cnt(cntA)
    );

    ikbd_keyscan_tx #(.SCAN_DIV(16), .BAUD_DIV(1000), .FIFO_DEPTH(4)) dutB (
        .clk(clk), .reset(resetB), .matrix(matrixB), .enable(enableB),
        .tx(txB), .tx_busy(busyB), .fifo_cnt(cntB)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Track the highest FIFO occupancy instance B ever shows.
    always @(negedge clk) begin
        if (cntB > 5'(maxCntB)) maxCntB = int'(cntB);
    end

    // Hard stop in case something never terminates.
    initial begin
        #(950000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int col, input int bitn, input logic level);
        matrixA[col][bitn] = level;
    endtask

    function automatic logic sampleTx(input int which);
        return (which == 0) ? txA : txB;
    endfunction

    function automatic logic sampleBusy(input int which);
        return (which == 0) ? busyA : busyB;
    endfunction

    // Wait (bounded) for a start bit, then sample every cycle of the frame:
    // each bit slot must hold one level for exactly 'baud' cycles, start
    // low, stop high, tx_busy high throughout. waited = idle cycles seen
    // before the start bit.
    task automatic captureFrame(input int which, input int baud, input int bound,
                                output logic [7:0] data, output logic ok,
                                output int waited);
        logic [9:0] slotv;
        logic       t;
        waited = 0;
        ok     = 1'b1;
        data   = 8'h00;
        slotv  = '0;
        while (1) begin
            @(negedge clk);
            if (sampleTx(which) == 1'b0) break;
            waited++;
            if (waited > bound) begin
                ok = 1'b0;
                return;
            end
        end
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < baud; c++) begin
                if (!(s == 0 && c == 0)) @(negedge clk);
                t = sampleTx(which);
                if (!sampleBusy(which)) ok = 1'b0;
                if (c == 0) slotv[s] = t;
                else if (t != slotv[s]) ok = 1'b0;
            end
        end
        if (slotv[0] != 1'b0 || slotv[9] != 1'b1) ok = 1'b0;
        data = slotv[8:1];
    endtask

    task automatic expectFrame(input string name, input logic [7:0] expByte,
                               input int bound);
        logic [7:0] d;
        logic       ok;
        int         w;
        captureFrame(0, 4, bound, d, ok, w);
        checkOutput({name, "_framing"}, 32'(ok), 32'd1);
        checkOutput({name, "_byte"}, 32'(d), 32'(expByte));
    endtask

    // Process for instance A: reset, idle passes, vector table, sequences.
    task automatic runA();
        logic [7:0] d;
        logic       ok;
        int         w;
        logic       noisy;

        // Reset values
        checkOutput("reset_tx", 32'(txA), 32'd1);
        checkOutput("reset_busy", 32'(busyA), 32'd0);
        checkOutput("reset_cnt", 32'(cntA), 32'd0);

        // Two full passes with nothing pressed
        noisy = 1'b0;
        for (int i = 0; i < 2 * 15 * 25; i++) begin
            @(negedge clk);
            if (txA !== 1'b1 || busyA !== 1'b0 || cntA !== 5'd0) noisy = 1'b1;
        end
        checkOutput("idle_passes_quiet", 32'(noisy), 32'd0);

        // Single-key vectors
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].col, vecs[v].bitn, vecs[v].level);
            expectFrame(vecs[v].name, vecs[v].expByte, 1000);
            repeat (2) @(negedge clk);
            checkOutput({vecs[v].name, "_cnt_after"}, 32'(cntA), 32'd0);
        end

        // Three keys of column 2 together, sent back to back
        matrixA[2][2:0] = 3'b000;
        captureFrame(0, 4, 1000, d, ok, w);
        checkOutput("col2_f0_ok", 32'(ok), 32'd1);
        checkOutput("col2_f0", 32'(d), 32'h11);
        for (int k = 1; k < 3; k++) begin
            captureFrame(0, 4, 1000, d, ok, w);
            checkOutput($sformatf("col2_f%0d_ok", k), 32'(ok), 32'd1);
            checkOutput($sformatf("col2_f%0d", k), 32'(d), 32'(8'h11 + k));
            checkOutput($sformatf("col2_f%0d_gap", k), 32'(w), 32'd0);
        end
        matrixA[2][2:0] = 3'b111;
        for (int k = 0; k < 3; k++) begin
            expectFrame($sformatf("col2_rel%0d", k), 8'h91 + 8'(k), 1000);
        end

        // Reset in the middle of a frame, keys held through reset
        matrixA[0][4] = 1'b0;
        matrixA[0][5] = 1'b0;
        w = 0;
        while (txA !== 1'b0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("rst_start_seen", 32'(txA), 32'd0);
        repeat (9) @(negedge clk);
        checkOutput("rst_pre_tx", 32'(txA), 32'd0);
        checkOutput("rst_pre_cnt", 32'(cntA), 32'd1);
        resetA = 1'b0;
        #1;
        checkOutput("rst_tx", 32'(txA), 32'd1);
        checkOutput("rst_cnt", 32'(cntA), 32'd0);
        checkOutput("rst_busy", 32'(busyA), 32'd0);
        repeat (3) @(negedge clk);
        resetA = 1'b1;
        expectFrame("held_0x05", 8'h05, 1000);
        captureFrame(0, 4, 1000, d, ok, w);
        checkOutput("held_0x06_ok", 32'(ok), 32'd1);
        checkOutput("held_0x06", 32'(d), 32'h06);
        checkOutput("held_0x06_gap", 32'(w), 32'd0);
        matrixA[0][4] = 1'b1;
        matrixA[0][5] = 1'b1;
        expectFrame("held_rel_0x85", 8'h85, 1000);
        expectFrame("held_rel_0x86", 8'h86, 1000);

        // Scanning paused: a change produces nothing until enable returns
        enableA = 1'b0;
        repeat (30) @(negedge clk);
        matrixA[14][7] = 1'b0;
        noisy = 1'b0;
        for (int i = 0; i < 2 * 15 * 25; i++) begin
            @(negedge clk);
            if (txA !== 1'b1 || busyA !== 1'b0 || cntA !== 5'd0) noisy = 1'b1;
        end
        checkOutput("paused_quiet", 32'(noisy), 32'd0);
        enableA = 1'b1;
        captureFrame(0, 4, 15 * 25 + 10, d, ok, w);
        checkOutput("resume_ok", 32'(ok), 32'd1);
        checkOutput("resume_0x78", 32'(d), 32'h78);
        // Column 0 only gets scanned again if the column counter wraps
        matrixA[0][0] = 1'b0;
        expectFrame("wrap_0x01", 8'h01, 15 * 25 + 10);
    endtask

    // Process for instance B: six keys in one column with a slow line.
    task automatic runB();
        logic [7:0] d;
        logic       ok;
        int         w;
        repeat (20) @(negedge clk);
        matrixB[7][5:0] = 6'b000000;
        for (int k = 0; k < 6; k++) begin
            captureFrame(1, 1000, 25000, d, ok, w);
            checkOutput($sformatf("stall_f%0d_ok", k), 32'(ok), 32'd1);
            checkOutput($sformatf("stall_f%0d", k), 32'(d), 32'(8'h39 + k));
        end
        checkOutput("stall_max_cnt", 32'(maxCntB), 32'd4);
        repeat (2) @(negedge clk);
        checkOutput("stall_cnt_end", 32'(cntB), 32'd0);
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        maxCntB   = 0;

        vecs[0] = '{"press_4_5",   4, 5, 1'b0, 8'h26};
        vecs[1] = '{"release_4_5", 4, 5, 1'b1, 8'hA6};
        vecs[2] = '{"press_0_0",   0, 0, 1'b0, 8'h01};
        vecs[3] = '{"release_0_0", 0, 0, 1'b1, 8'h81};
        vecs[4] = '{"press_14_7",  14, 7, 1'b0, 8'h78};
        vecs[5] = '{"release_14_7", 14, 7, 1'b1, 8'hF8};
        vecs[6] = '{"press_9_3",   9, 3, 1'b0, 8'h4C};
        vecs[7] = '{"release_9_3", 9, 3, 1'b1, 8'hCC};

        resetA  = 1'b0;
        resetB  = 1'b0;
        enableA = 1'b1;
        enableB = 1'b1;
        for (int c = 0; c < 15; c++) begin
            matrixA[c] = 8'hFF;
            matrixB[c] = 8'hFF;
        end
        repeat (3) @(negedge clk);
        resetA = 1'b1;
        resetB = 1'b1;
        #1;

        fork
            runA();
            runB();
        join

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
